// File: rtl/mse_loss_accum_pkg.sv
// Shared types and constant helpers for the MSE loss accumulator.
package mse_loss_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    function automatic int clog2(input int unsigned value);
        int          bits;
        int unsigned span;
        bits = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sq_err_stage.sv
// Two-stage squared-error pipeline: registered difference, then registered square.
module sq_err_stage #(
    parameter int DATA_W = 21,
    parameter int TGT_W  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         predicted,
    input  logic [TGT_W-1:0]          target,
    output logic                      out_valid,
    output logic [2*(DATA_W+1)-1:0]   sq
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int SQ_W   = 2 * DIFF_W;

    logic signed [DIFF_W-1:0] pred_ext;
    logic signed [DIFF_W-1:0] tgt_ext;
    logic signed [DIFF_W-1:0] diff;
    logic signed [SQ_W-1:0]   prod;
    logic                     diff_valid;

    always_comb begin
        pred_ext = {predicted[DATA_W-1], predicted};
        tgt_ext  = DIFF_W'(target);
        prod     = diff * diff;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            diff       <= '0;
            diff_valid <= 1'b0;
            sq         <= '0;
            out_valid  <= 1'b0;
        end else begin
            diff       <= pred_ext - tgt_ext;
            diff_valid <= in_valid;
            sq         <= prod;
            out_valid  <= diff_valid;
        end
    end

endmodule

// File: rtl/mse_loss_accum.sv
// Batch mean/sum squared-error accumulator with saturating accumulator and sticky overflow.
module mse_loss_accum
    import mse_loss_accum_pkg::*;
#(
    parameter int DATA_W    = 21,
    parameter int TGT_W     = 4,
    parameter int BATCH_N   = 8,
    parameter int MEAN_MODE = 1,
    parameter int ACC_W     = 2 * (DATA_W + 1) + clog2(BATCH_N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    input  logic [TGT_W-1:0]  target_i,
    input  logic [DATA_W-1:0] predicted_i,
    output logic [ACC_W-1:0]  loss_o,
    output logic              loss_valid_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int LOG2N = clog2(BATCH_N);
    localparam int SQ_W  = 2 * (DATA_W + 1);
    localparam int MAX_W = (ACC_W > SQ_W) ? ACC_W : SQ_W;
    localparam int SUM_W = MAX_W + 1;
    localparam int CNT_W = LOG2N + 1;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               drain_cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   loss_next;
    logic [SUM_W-1:0]   sum;
    logic               sat;
    logic               accept;
    logic               sq_valid;
    logic [SQ_W-1:0]    sq;

    sq_err_stage #(
        .DATA_W (DATA_W),
        .TGT_W  (TGT_W)
    ) u_sq_err_stage (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (accept),
        .predicted (predicted_i),
        .target    (target_i),
        .out_valid (sq_valid),
        .sq        (sq)
    );

    // Sum is computed one bit wider than either operand so saturation is a simple carry test.
    always_comb begin
        accept    = sample_valid_i & sample_ready_o;
        sum       = SUM_W'(acc) + SUM_W'(sq);
        sat       = |sum[SUM_W-1:ACC_W];
        loss_next = (MEAN_MODE != 0) ? (acc >> LOG2N) : acc;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            count          <= '0;
            drain_cnt      <= 1'b0;
            acc            <= '0;
            loss_o         <= '0;
            loss_valid_o   <= 1'b0;
            busy_o         <= 1'b0;
            overflow_o     <= 1'b0;
            sample_ready_o <= 1'b0;
        end else begin
            loss_valid_o <= 1'b0;
            if (sq_valid) begin
                if (sat) begin
                    acc        <= '1;
                    overflow_o <= 1'b1;
                end else begin
                    acc <= sum[ACC_W-1:0];
                end
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state          <= ACCUM;
                        acc            <= '0;
                        count          <= '0;
                        overflow_o     <= 1'b0;
                        sample_ready_o <= 1'b1;
                        busy_o         <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(BATCH_N - 1)) begin
                            state          <= DRAIN;
                            sample_ready_o <= 1'b0;
                            drain_cnt      <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    loss_o       <= loss_next;
                    loss_valid_o <= 1'b1;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
